// File: rtl/enc_pkg.sv
// Shared types and constant functions for the extended-Hamming (SECDED) encoder.
// Mode m: codeword 2^(m+3) bits, m+3 Hamming checks plus one overall parity bit.
package enc_pkg;

    typedef logic [1:0] mode_t;

    function automatic int n_of(input int m);
        return m + 3;
    endfunction

    function automatic int p_of(input int m);
        return m + 4;
    endfunction

    function automatic int cw_of(input int m);
        return 1 << (m + 3);
    endfunction

    function automatic int k_of(input int m);
        return cw_of(m) - p_of(m);
    endfunction

    function automatic int max_n_of(input int n_modes);
        return 1 << (n_modes + 2);
    endfunction

    function automatic int max_k_of(input int n_modes);
        return max_n_of(n_modes) - n_modes - 3;
    endfunction

    // i-th integer >= 3 that is not a power of two: 3, 5, 6, 7, 9, ...
    function automatic int s_of(input int i);
        int v;
        int c;
        v = 2;
        c = -1;
        while (c < i) begin
            v = v + 1;
            if ((v & (v - 1)) != 0) c = c + 1;
        end
        return v;
    endfunction

    // Info bits (below k) whose syndrome value has bit j set.
    function automatic logic [63:0] sel_mask(input int j, input int k);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < k; i++) begin
            if (((s_of(i) >> j) & 1) != 0) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/enc_hamming_checks.sv
// Combinational Hamming check-bit generator; info must already be masked to K bits.
// Checks beyond the mode's own count are forced to zero.
module enc_hamming_checks
    import enc_pkg::*;
#(
    parameter int N_MODES = 3,
    localparam int MAX_K = max_k_of(N_MODES),
    localparam int CW = N_MODES + 2
) (
    input  logic [MAX_K-1:0] info,
    input  mode_t            mode,
    output logic [CW-1:0]    checks
);

    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_chk
            localparam logic [63:0] SEL64 = sel_mask(gi, MAX_K);
            localparam logic [MAX_K-1:0] SEL = SEL64[MAX_K-1:0];
            assign checks[gi] = (^(info & SEL)) & (gi < n_of(int'(mode)));
        end
    endgenerate

endmodule

// File: rtl/ehc_encoder_pipe.sv
// Two-stage pipelined SECDED encoder with valid/ready on both sides.
// Optional macro ENC_ERR_INJECT_EN adds inj_en/inj_pos to flip one codeword bit in S2.
module ehc_encoder_pipe
    import enc_pkg::*;
#(
    parameter int N_MODES = 3,
    localparam int MAX_N = max_n_of(N_MODES),
    localparam int MAX_K = max_k_of(N_MODES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  mode_t            in_mode,
    input  logic [MAX_K-1:0] in_info,
`ifdef ENC_ERR_INJECT_EN
    input  logic                       inj_en,
    input  logic [$clog2(MAX_N)-1:0]   inj_pos,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAX_N-1:0] out_codeword,
    output mode_t            out_mode,
    output logic             out_mode_err
);

    localparam int CW = N_MODES + 2;

    logic s1_adv, s2_adv;

    logic             s1_valid_reg;
    logic [MAX_K-1:0] s1_info_reg;
    mode_t            s1_mode_reg;
    logic             s1_err_reg;
    logic [CW-1:0]    s1_checks_reg;

    logic             s2_valid_reg;
    logic [MAX_N-1:0] s2_cw_reg;
    mode_t            s2_mode_reg;
    logic             s2_err_reg;

    logic [MAX_K-1:0] info_next;
    logic             err_next;
    logic [CW-1:0]    checks_next;
    logic [MAX_N-1:0] cw_next;
    logic             parity;
    int               p_cur;

`ifdef ENC_ERR_INJECT_EN
    logic                     s1_inj_en_reg;
    logic [$clog2(MAX_N)-1:0] s1_inj_pos_reg;
`endif

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // Unsupported modes carry an all-zero word so the codeword comes out zero.
    always_comb begin
        err_next  = int'(in_mode) >= N_MODES;
        info_next = '0;
        for (int i = 0; i < MAX_K; i++) begin
            info_next[i] = in_info[i] & (i < k_of(int'(in_mode))) & !err_next;
        end
    end

    enc_hamming_checks #(.N_MODES(N_MODES)) u_checks (
        .info   (info_next),
        .mode   (in_mode),
        .checks (checks_next)
    );

    always_comb begin
        p_cur   = p_of(int'(s1_mode_reg));
        parity  = (^s1_info_reg) ^ (^s1_checks_reg);
        cw_next = (MAX_N'(s1_info_reg) << p_cur)
                | (MAX_N'(parity) << (p_cur - 1))
                | MAX_N'(s1_checks_reg);
        if (s1_err_reg) cw_next = '0;
`ifdef ENC_ERR_INJECT_EN
        if (s1_inj_en_reg && !s1_err_reg &&
            int'(s1_inj_pos_reg) < cw_of(int'(s1_mode_reg))) begin
            cw_next[s1_inj_pos_reg] = ~cw_next[s1_inj_pos_reg];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_info_reg   <= '0;
            s1_mode_reg   <= '0;
            s1_err_reg    <= 1'b0;
            s1_checks_reg <= '0;
            s2_valid_reg  <= 1'b0;
            s2_cw_reg     <= '0;
            s2_mode_reg   <= '0;
            s2_err_reg    <= 1'b0;
`ifdef ENC_ERR_INJECT_EN
            s1_inj_en_reg  <= 1'b0;
            s1_inj_pos_reg <= '0;
`endif
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_info_reg   <= info_next;
                    s1_mode_reg   <= in_mode;
                    s1_err_reg    <= err_next;
                    s1_checks_reg <= checks_next;
`ifdef ENC_ERR_INJECT_EN
                    s1_inj_en_reg  <= inj_en;
                    s1_inj_pos_reg <= inj_pos;
`endif
                end
            end
            // S2 only reloads when its word is taken, so stalled outputs hold.
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_cw_reg   <= cw_next;
                    s2_mode_reg <= s1_mode_reg;
                    s2_err_reg  <= s1_err_reg;
                end
            end
        end
    end

    assign out_valid    = s2_valid_reg;
    assign out_codeword = s2_cw_reg;
    assign out_mode     = s2_mode_reg;
    assign out_mode_err = s2_err_reg;

endmodule
